// File: rtl/l1_dcache_pkg.sv
// Shared widths and state encoding for the L1 data cache.
package l1_cache_types;

   localparam int unsigned ADDR_W     = 32;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned OFFSET_W   = 5;
   localparam int unsigned WORD_SEL_W = 3;
   localparam int unsigned LINE_W     = 256;
   localparam int unsigned LINE_BYTES = LINE_W / 8;
   localparam int unsigned LINE_WORDS = LINE_W / WORD_W;

   typedef enum logic [1:0] {
      CHECK     = 2'd0,
      WRITEBACK = 2'd1,
      FILL      = 2'd2
   } dcache_state_t;

   // Tag width for a given number of index bits.
   function automatic int unsigned tag_width(input int unsigned s_index);
      return ADDR_W - OFFSET_W - s_index;
   endfunction

endpackage

// File: rtl/l1_dcache_if.sv
// CPU-side word port and line-memory port of the L1 data cache.
interface l1_dcache_cpu_if;
   import l1_cache_types::*;

   logic                mem_read;
   logic                mem_write;
   logic [ADDR_W-1:0]   mem_address;
   logic [WORD_W-1:0]   mem_wdata;
   logic [3:0]          mem_byte_enable;
   logic [WORD_W-1:0]   mem_rdata;
   logic                mem_resp;

   modport master (
      output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      input  mem_rdata, mem_resp
   );

   modport slave (
      input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      output mem_rdata, mem_resp
   );
endinterface

interface l1_dcache_pmem_if;
   import l1_cache_types::*;

   logic                pmem_read;
   logic                pmem_write;
   logic [ADDR_W-1:0]   pmem_address;
   logic [LINE_W-1:0]   pmem_wdata;
   logic [LINE_W-1:0]   pmem_rdata;
   logic                pmem_resp;

   modport master (
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport slave (
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/l1_dcache_array.sv
// Flop-based tag/valid/dirty/data storage: one combinational read port, one write port.
module l1d_array
   import l1_cache_types::*;
#(
   parameter  int unsigned S_INDEX = 4,
   localparam int unsigned TAG_W   = ADDR_W - OFFSET_W - S_INDEX,
   localparam int unsigned SETS    = 1 << S_INDEX
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [S_INDEX-1:0]    idx,
   output logic [TAG_W-1:0]      rd_tag,
   output logic                  rd_valid,
   output logic                  rd_dirty,
   output logic [LINE_W-1:0]     rd_data,
   input  logic [LINE_BYTES-1:0] wr_be,
   input  logic [LINE_W-1:0]     wr_data,
   input  logic                  fill,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic                  dirty_set,
   input  logic                  dirty_clr
);

   logic [TAG_W-1:0]  tag_arr [SETS];
   logic [LINE_W-1:0] data    [SETS];
   logic [SETS-1:0]   valid;
   logic [SETS-1:0]   dirty;

   assign rd_tag   = tag_arr[idx];
   assign rd_valid = valid[idx];
   assign rd_dirty = dirty[idx];
   assign rd_data  = data[idx];

   // Byte-granular line write and tag update; contents are not reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < int'(LINE_BYTES); b++) begin
         if (wr_be[b]) begin
            data[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
      if (fill) begin
         tag_arr[idx] <= wr_tag;
      end
   end

   // Valid/dirty state, cleared asynchronously so a reset invalidates the whole cache.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= '0;
         dirty <= '0;
      end else if (fill) begin
         valid[idx] <= 1'b1;
         dirty[idx] <= 1'b0;
      end else if (dirty_set) begin
         dirty[idx] <= 1'b1;
      end else if (dirty_clr) begin
         dirty[idx] <= 1'b0;
      end
   end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back, write-allocate L1 data cache: FSM, hit compare, word select, byte merge.
module l1_dcache
   import l1_cache_types::*;
#(
   parameter int unsigned S_INDEX = 4,
   parameter int unsigned S_LINE  = 256
) (
   input  logic            clk,
   input  logic            rst,
   l1_dcache_cpu_if.slave  cpu,
   l1_dcache_pmem_if.master pmem
);

   localparam int unsigned TAG_W = ADDR_W - OFFSET_W - S_INDEX;

   dcache_state_t          state_q, state_d;

   logic [TAG_W-1:0]       req_tag, miss_tag_q, arr_tag;
   logic [S_INDEX-1:0]     req_idx, miss_idx_q, arr_idx;
   logic [WORD_SEL_W-1:0]  req_word;
   logic                   req, hit, miss_start;
   logic                   arr_valid, arr_dirty;
   logic [S_LINE-1:0]      line_rd;

   logic                   resp_c, pmem_read_c, pmem_write_c;
   logic [ADDR_W-1:0]      pmem_address_c;
   logic [LINE_BYTES-1:0]  wr_be_c;
   logic [LINE_W-1:0]      wr_data_c;
   logic                   fill_c, dirty_set_c, dirty_clr_c;
   logic                   unused_addr_lsb;

   assign req_tag  = cpu.mem_address[ADDR_W-1 -: TAG_W];
   assign req_idx  = cpu.mem_address[OFFSET_W +: S_INDEX];
   assign req_word = cpu.mem_address[2 +: WORD_SEL_W];
   assign unused_addr_lsb = ^cpu.mem_address[1:0];

   // During a miss the array is addressed by the latched miss set, not the live CPU address.
   assign arr_idx    = (state_q == CHECK) ? req_idx : miss_idx_q;
   assign req        = cpu.mem_read | cpu.mem_write;
   assign hit        = req & arr_valid & (arr_tag == req_tag);
   assign miss_start = (state_q == CHECK) & req & ~hit;

   l1d_array #(.S_INDEX(S_INDEX)) u_array (
      .clk       (clk),
      .rst       (rst),
      .idx       (arr_idx),
      .rd_tag    (arr_tag),
      .rd_valid  (arr_valid),
      .rd_dirty  (arr_dirty),
      .rd_data   (line_rd),
      .wr_be     (wr_be_c),
      .wr_data   (wr_data_c),
      .fill      (fill_c),
      .wr_tag    (miss_tag_q),
      .dirty_set (dirty_set_c),
      .dirty_clr (dirty_clr_c)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= CHECK;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the missing line's tag/set so the fill completes even if the CPU drops its request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         miss_tag_q <= '0;
         miss_idx_q <= '0;
      end else if (miss_start) begin
         miss_tag_q <= req_tag;
         miss_idx_q <= req_idx;
      end
   end

   // Next state, CPU response, line-memory requests and array write controls.
   always_comb begin
      state_d        = state_q;
      resp_c         = 1'b0;
      pmem_read_c    = 1'b0;
      pmem_write_c   = 1'b0;
      pmem_address_c = '0;
      wr_be_c        = '0;
      wr_data_c      = {LINE_WORDS{cpu.mem_wdata}};
      fill_c         = 1'b0;
      dirty_set_c    = 1'b0;
      dirty_clr_c    = 1'b0;

      unique case (state_q)
         CHECK: begin
            if (req) begin
               if (hit) begin
                  resp_c = 1'b1;
                  if (cpu.mem_write) begin
                     wr_be_c     = LINE_BYTES'(cpu.mem_byte_enable) << {req_word, 2'b00};
                     dirty_set_c = 1'b1;
                  end
               end else if (arr_valid && arr_dirty) begin
                  state_d = WRITEBACK;
               end else begin
                  state_d = FILL;
               end
            end
         end
         WRITEBACK: begin
            pmem_write_c   = 1'b1;
            pmem_address_c = {arr_tag, miss_idx_q, OFFSET_W'(0)};
            if (pmem.pmem_resp) begin
               dirty_clr_c = 1'b1;
               state_d     = FILL;
            end
         end
         FILL: begin
            pmem_read_c    = 1'b1;
            pmem_address_c = {miss_tag_q, miss_idx_q, OFFSET_W'(0)};
            wr_data_c      = pmem.pmem_rdata;
            if (pmem.pmem_resp) begin
               wr_be_c = '1;
               fill_c  = 1'b1;
               state_d = CHECK;
            end
         end
         default: begin
            state_d = CHECK;
         end
      endcase
   end

   assign cpu.mem_resp      = resp_c;
   assign cpu.mem_rdata     = line_rd[{req_word, 5'b00000} +: WORD_W];
   assign pmem.pmem_read    = pmem_read_c;
   assign pmem.pmem_write   = pmem_write_c;
   assign pmem.pmem_address = pmem_address_c;
   assign pmem.pmem_wdata   = line_rd;

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: directed scenarios plus random traffic against a flat memory model.
module tb_l1_dcache;
   import l1_cache_types::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   l1_dcache_cpu_if  cpu ();
   l1_dcache_pmem_if pm ();

   l1_dcache #(.S_INDEX(4), .S_LINE(256)) dut (
      .clk  (clk),
      .rst  (rst),
      .cpu  (cpu.slave),
      .pmem (pm.master)
   );

   int errors = 0;
   int checks = 0;
   int resp_cnt = 0;

   int  fixed_lat = 0;
   bit  rand_lat = 0;
   bit  overlap_seen = 0;
   logic [31:0]  fill_q [$];
   logic [31:0]  wb_q [$];
   logic [255:0] wbd_q [$];

   logic [31:0]  gold   [logic [31:0]];
   logic [255:0] pmem_m [logic [31:0]];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Initial content of every word of backing memory.
   function automatic logic [31:0] dflt_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] gold_rd(input logic [31:0] a);
      return gold.exists(a) ? gold[a] : dflt_word(a);
   endfunction

   function automatic logic [255:0] gold_line(input logic [31:0] la);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = gold_rd(la + 32'(i*4));
      return l;
   endfunction

   function automatic logic [255:0] pmem_line(input logic [31:0] la);
      logic [255:0] l;
      if (pmem_m.exists(la)) return pmem_m[la];
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = dflt_word(la + 32'(i*4));
      return l;
   endfunction

   task automatic gold_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] w;
      w = gold_rd(a);
      for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      gold[a] = w;
   endtask

   // Line-memory responder with programmable or random latency.
   initial begin
      int cnt, cur;
      bit started;
      cnt = 0; cur = 0; started = 0;
      pm.pmem_resp  = 1'b0;
      pm.pmem_rdata = '0;
      forever begin
         @(negedge clk);
         pm.pmem_resp = 1'b0;
         if (pm.pmem_read && pm.pmem_write) overlap_seen = 1'b1;
         if (!rst || !(pm.pmem_read || pm.pmem_write)) begin
            cnt = 0;
            started = 0;
         end else begin
            if (!started) begin
               cur = rand_lat ? int'($urandom_range(0, 10)) : fixed_lat;
               started = 1;
               cnt = 0;
            end
            if (cnt == cur) begin
               pm.pmem_resp = 1'b1;
               started = 0;
               if (pm.pmem_read) begin
                  pm.pmem_rdata = pmem_line(pm.pmem_address);
                  fill_q.push_back(pm.pmem_address);
               end else begin
                  pmem_m[pm.pmem_address] = pm.pmem_wdata;
                  wb_q.push_back(pm.pmem_address);
                  wbd_q.push_back(pm.pmem_wdata);
               end
            end else begin
               cnt++;
            end
         end
      end
   end

   // Count CPU response pulses once per cycle.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (cpu.mem_resp === 1'b1) resp_cnt++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one request at a negedge; returns at the negedge after the response with the request dropped.
   task automatic cpu_req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rdata, output int cyc, output bit tmo);
      cpu.mem_read = rd;
      cpu.mem_write = wr;
      cpu.mem_address = a;
      cpu.mem_wdata = wd;
      cpu.mem_byte_enable = be;
      cyc = 0;
      tmo = 0;
      #1;
      while (cpu.mem_resp !== 1'b1 && !tmo) begin
         @(negedge clk);
         #1;
         cyc++;
         if (cyc > 200) tmo = 1;
      end
      rdata = cpu.mem_rdata;
      @(negedge clk);
      cpu.mem_read = 1'b0;
      cpu.mem_write = 1'b0;
   endtask

   task automatic access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input string tag, output int cyc, output logic [31:0] rdata);
      int r0;
      bit tmo;
      logic [31:0] exp;
      r0 = resp_cnt;
      exp = gold_rd(a);
      cpu_req(wr, rd, a, wd, be, rdata, cyc, tmo);
      chk({tag, "_timeout"}, 256'(tmo), 256'(0));
      chk({tag, "_resp_count"}, 256'(resp_cnt - r0), 256'(1));
      if (!wr) chk({tag, "_rdata"}, 256'(rdata), 256'(exp));
      else     gold_wr(a, wd, be);
   endtask

   initial begin
      int cyc, n, nw;
      logic [31:0] rd;
      logic [31:0] exp2;
      logic [255:0] line_exp;

      cpu.mem_read = 1'b0;
      cpu.mem_write = 1'b0;
      cpu.mem_address = '0;
      cpu.mem_wdata = '0;
      cpu.mem_byte_enable = '0;
      rst = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_mem_resp", 256'(cpu.mem_resp), 256'(0));
      chk("rst_pmem_read", 256'(pm.pmem_read), 256'(0));
      chk("rst_pmem_write", 256'(pm.pmem_write), 256'(0));
      chk("rst_pmem_address", 256'(pm.pmem_address), 256'(0));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // 1: cold read miss, fill latency 5
      fixed_lat = 5;
      n = fill_q.size();
      access(0, 1, 32'h40, 32'h0, 4'h0, "t1", cyc, rd);
      chk("t1_cycles", 256'(cyc), 256'(7));
      chk("t1_fill_count", 256'(fill_q.size()), 256'(n + 1));
      chk("t1_fill_addr", 256'(fill_q[$]), 256'(32'h40));
      chk("t1_no_writeback", 256'(wb_q.size()), 256'(0));
      chk("t1_word0", 256'(rd), 256'(dflt_word(32'h40)));

      // 2: write hit with one byte lane, then read it back
      access(1, 0, 32'h44, 32'hAAAA_AAAA, 4'b0010, "t2w", cyc, rd);
      chk("t2w_cycles", 256'(cyc), 256'(0));
      access(0, 1, 32'h44, 32'h0, 4'h0, "t2r", cyc, rd);
      chk("t2r_cycles", 256'(cyc), 256'(0));
      exp2 = dflt_word(32'h44);
      exp2[15:8] = 8'hAA;
      chk("t2r_merged", 256'(rd), 256'(exp2));

      // 3: conflicting read evicts the dirty line
      fixed_lat = 2;
      nw = wb_q.size();
      line_exp = gold_line(32'h40);
      access(0, 1, 32'h240, 32'h0, 4'h0, "t3", cyc, rd);
      chk("t3_cycles", 256'(cyc), 256'(7));
      chk("t3_wb_count", 256'(wb_q.size()), 256'(nw + 1));
      chk("t3_wb_addr", 256'(wb_q[$]), 256'(32'h40));
      chk("t3_wb_data", wbd_q[$], line_exp);
      chk("t3_fill_addr", 256'(fill_q[$]), 256'(32'h240));
      chk("t3_no_overlap", 256'(overlap_seen), 256'(0));

      // 4: refill 0x40, then four back-to-back hits
      fixed_lat = 1;
      access(0, 1, 32'h40, 32'h0, 4'h0, "t4m", cyc, rd);
      chk("t4m_cycles", 256'(cyc), 256'(3));
      for (int i = 0; i < 4; i++) begin
         access(0, 1, 32'h40 + 32'(i*4), 32'h0, 4'h0, $sformatf("t4h%0d", i), cyc, rd);
         chk($sformatf("t4h%0d_cycles", i), 256'(cyc), 256'(0));
      end

      // 5: asynchronous reset in the middle of a fill
      fixed_lat = 20;
      cpu.mem_read = 1'b1;
      cpu.mem_address = 32'h840;
      @(negedge clk);
      #1;
      chk("t5_fill_active", 256'(pm.pmem_read), 256'(1));
      #2;
      rst = 1'b0;
      #1;
      chk("t5_pmem_read_drop", 256'(pm.pmem_read), 256'(0));
      chk("t5_pmem_addr_drop", 256'(pm.pmem_address), 256'(0));
      cpu.mem_read = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      fixed_lat = 1;
      n = fill_q.size();
      access(0, 1, 32'h40, 32'h0, 4'h0, "t5", cyc, rd);
      chk("t5_cycles", 256'(cyc), 256'(3));
      chk("t5_fill_count", 256'(fill_q.size()), 256'(n + 1));
      chk("t5_fill_addr", 256'(fill_q[$]), 256'(32'h40));

      // 6: random traffic with random line-memory latency
      rand_lat = 1;
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a, wd;
         logic [3:0]  be;
         int kind;
         a = 32'($urandom_range(0, 511)) << 2;
         wd = $urandom;
         be = 4'($urandom_range(0, 15));
         kind = int'($urandom_range(0, 9));
         if (kind <= 4)      access(0, 1, a, wd, be, "t6r", cyc, rd);
         else if (kind <= 8) access(1, 0, a, wd, be, "t6w", cyc, rd);
         else                access(1, 1, a, wd, be, "t6rw", cyc, rd);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      chk("t6_no_overlap", 256'(overlap_seen), 256'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
